// File: rtl/seven_segment_arbiter_if.sv
// Display-sharing bus between requesters and the seven-segment arbiter.
// The arbiter side registers every output, so grant and data arrive one clock after the request.
// There is no backpressure: requests are level-sensitive and stay asserted until the requester is served.
interface seven_segment_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_SEGMENTS = 2
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                        req;
    logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0][3:0] req_encoded;
    logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0]      req_dp;
    logic [NUM_REQ-1:0]                        grant;
    logic [IW-1:0]                             owner_idx;
    logic                                      disp_valid;
    logic [NUM_SEGMENTS-1:0][3:0]              encoded;
    logic [NUM_SEGMENTS-1:0]                   digit_point;

    // Arbiter side.
    modport slave (
        input  req, req_encoded, req_dp,
        output grant, owner_idx, disp_valid, encoded, digit_point
    );

    // Requester / display-driver side.
    modport master (
        output req, req_encoded, req_dp,
        input  grant, owner_idx, disp_valid, encoded, digit_point
    );
endinterface

// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter that hands one shared seven-segment display to NUM_REQ requesters for at least HOLD_CYCLES each.
// Latency: grant, owner_idx, disp_valid and display data are all registered and appear one clk after they are decided.
// No backpressure: an owner keeps the display for the minimum hold even if its req drops. Define SEG_ARB_OWNER_DP_EN to show the owner index on the digit points.
module seven_segment_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_SEGMENTS = 2,
    parameter int HOLD_CYCLES  = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    seven_segment_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [IW-1:0]                rr_start;
    logic [NUM_REQ-1:0]           grant_q;
    logic [IW-1:0]                owner_q;
    logic                         vld_q;
    logic [NUM_SEGMENTS-1:0][3:0] enc_q;
    logic [NUM_SEGMENTS-1:0]      dp_q;

    logic [NUM_REQ-1:0]           cand;
    logic                         win_found;
    logic [IW-1:0]                win_idx;
    logic                         owner_req;
    logic                         eval_open;

    // Round-robin search from rr_start; the current owner never competes against itself.
    always_comb begin
        int idx;
        idx       = 0;
        cand      = bus.req & ~grant_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_start) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    // The last hold cycle applies the open-window rules directly, so there is no dead cycle before a switch.
    always_comb begin
        owner_req = bus.req[owner_q];
        eval_open = (state == OPEN) ||
                    ((state == HOLD) && (cnt == CW'(HOLD_CYCLES - 1)));
    end

    // Arbitration state machine; every bus output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_start <= '0;
            grant_q  <= '0;
            owner_q  <= '0;
            vld_q    <= 1'b0;
            enc_q    <= '0;
            dp_q     <= '0;
        end else begin
            case (state)
                IDLE, HOLD, OPEN: begin
                    if ((state == IDLE || eval_open) && win_found) begin
                        // Hand over: new owner's data lands on the same edge as its grant.
                        state    <= HOLD;
                        cnt      <= '0;
                        grant_q  <= NUM_REQ'(1) << win_idx;
                        owner_q  <= win_idx;
                        vld_q    <= 1'b1;
                        rr_start <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
                        enc_q    <= bus.req_encoded[win_idx];
`ifdef SEG_ARB_OWNER_DP_EN
                        dp_q     <= NUM_SEGMENTS'(win_idx);
`else
                        dp_q     <= bus.req_dp[win_idx];
`endif
                    end else if (state == IDLE) begin
                        grant_q <= '0;
                        vld_q   <= 1'b0;
                    end else if (eval_open && !owner_req) begin
                        // Owner gone and nobody waiting: release the display, keep the last digits.
                        state   <= IDLE;
                        grant_q <= '0;
                        vld_q   <= 1'b0;
`ifdef SEG_ARB_OWNER_DP_EN
                        dp_q    <= '0;
`endif
                    end else begin
                        if (eval_open) begin
                            state <= OPEN;
                            cnt   <= CW'(HOLD_CYCLES);
                        end else begin
                            cnt   <= cnt + CW'(1);
                        end
                        // Track the owner's data only while it is asking; otherwise freeze.
                        if (owner_req) begin
                            enc_q <= bus.req_encoded[owner_q];
`ifndef SEG_ARB_OWNER_DP_EN
                            dp_q  <= bus.req_dp[owner_q];
`endif
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner_idx   = owner_q;
    assign bus.disp_valid  = vld_q;
    assign bus.encoded     = enc_q;
    assign bus.digit_point = dp_q;
endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed bench for seven_segment_arbiter with NUM_REQ=4, NUM_SEGMENTS=2, HOLD_CYCLES=4.
// Each table row is applied for one clock and all outputs are compared 1 time unit after the edge.
// Requester i drives digits {tag, A+i} and digit points tag[1:0]^i so the owner is visible in the data.
module tb_seven_segment_arbiter;
    localparam int NR = 4;
    localparam int NS = 2;
    localparam int HC = 4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] tag;
        logic [3:0] e_grant;
        logic [1:0] e_own;
        logic       e_vld;
        logic [7:0] e_enc;
        logic [1:0] e_dp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   row    = 0;

    seven_segment_arbiter_if #(.NUM_REQ(NR), .NUM_SEGMENTS(NS)) bus ();

    seven_segment_arbiter #(
        .NUM_REQ      (NR),
        .NUM_SEGMENTS (NS),
        .HOLD_CYCLES  (HC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic rst, input logic [3:0] req, input logic [3:0] tag,
                       input logic [3:0] eg, input logic [1:0] eo, input logic ev,
                       input logic [7:0] ee, input logic [1:0] ed);
        vec_t v;
        v.rst = rst; v.req = req; v.tag = tag;
        v.e_grant = eg; v.e_own = eo; v.e_vld = ev; v.e_enc = ee;
`ifdef SEG_ARB_OWNER_DP_EN
        v.e_dp = ev ? eo : 2'b00;
`else
        v.e_dp = ed;
`endif
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] tag);
        reset   = rst;
        bus.req = req;
        for (int i = 0; i < NR; i++) begin
            bus.req_encoded[i] = {tag, 4'hA + 4'(i)};
            bus.req_dp[i]      = tag[1:0] ^ 2'(i);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input vec_t v);
        chk("grant",       32'(bus.grant),       32'(v.e_grant));
        chk("owner_idx",   32'(bus.owner_idx),   32'(v.e_own));
        chk("disp_valid",  32'(bus.disp_valid),  32'(v.e_vld));
        chk("encoded",     32'(bus.encoded),     32'(v.e_enc));
        chk("digit_point", 32'(bus.digit_point), 32'(v.e_dp));
    endtask

    initial begin
        vec_t rv;
        int   waited;

        // Single owner, req dropped mid-hold: exactly four grant cycles, data frozen, then idle.
        add(2, 0, 4'b0001, 4'h3, 4'b0001, 0, 1, 8'h3A, 2'd3);
        add(2, 0, 4'b0000, 4'h5, 4'b0001, 0, 1, 8'h3A, 2'd3);
        add(2, 0, 4'b0000, 4'h5, 4'b0000, 0, 0, 8'h3A, 2'd3);
        // Reset restarts the round-robin at 0; two contenders alternate with no idle gap.
        add(1, 1, 4'b0000, 4'h5, 4'b0000, 0, 0, 8'h00, 2'd0);
        add(4, 0, 4'b1010, 4'h1, 4'b0010, 1, 1, 8'h1B, 2'd0);
        add(4, 0, 4'b1010, 4'h1, 4'b1000, 3, 1, 8'h1D, 2'd2);
        add(1, 0, 4'b1010, 4'h1, 4'b0010, 1, 1, 8'h1B, 2'd0);
        // Owner 1 drops while requester 2 waits: freeze, then switch at hold end.
        add(3, 0, 4'b0100, 4'h2, 4'b0010, 1, 1, 8'h1B, 2'd0);
        add(5, 0, 4'b0100, 4'h2, 4'b0100, 2, 1, 8'h2C, 2'd0);
        add(1, 0, 4'b0100, 4'h7, 4'b0100, 2, 1, 8'h7C, 2'd1);
        // Owner 2 in the open window; requester 0 arrives and wins on the next edge.
        add(1, 0, 4'b0101, 4'h7, 4'b0001, 0, 1, 8'h7A, 2'd3);
        add(3, 0, 4'b1000, 4'h7, 4'b0001, 0, 1, 8'h7A, 2'd3);
        add(6, 0, 4'b1000, 4'h7, 4'b1000, 3, 1, 8'h7D, 2'd0);
        // Owner 3 open, requester 0 arrives: search wraps to index 0.
        add(1, 0, 4'b1001, 4'h7, 4'b0001, 0, 1, 8'h7A, 2'd3);
        add(2, 0, 4'b0001, 4'h7, 4'b0001, 0, 1, 8'h7A, 2'd3);
        // Reset during the cnt=2 hold cycle, then a fresh request one cycle later.
        add(1, 1, 4'b0001, 4'h7, 4'b0000, 0, 0, 8'h00, 2'd0);
        add(5, 0, 4'b0010, 4'h4, 4'b0010, 1, 1, 8'h4B, 2'd1);
        // Open owner drops with nobody waiting: back to idle, data held.
        add(1, 0, 4'b0000, 4'h4, 4'b0000, 1, 0, 8'h4B, 2'd1);
        // From idle with last owner 1, search starts at 2 and wraps to 0.
        add(1, 0, 4'b0011, 4'h4, 4'b0001, 0, 1, 8'h4A, 2'd0);

        drive(1, 4'b0000, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        row = -1;
        rv.e_grant = '0; rv.e_own = '0; rv.e_vld = 1'b0; rv.e_enc = '0; rv.e_dp = '0;
        chk_all(rv);

        foreach (vecs[k]) begin
            row = k;
            drive(vecs[k].rst, vecs[k].req, vecs[k].tag);
            @(posedge clk);
            #1;
            chk_all(vecs[k]);
        end

        // Lone requester stays granted well past the hold time.
        row = 1000;
        drive(1, 4'b0000, 4'h9);
        @(posedge clk);
        #1;
        drive(0, 4'b0100, 4'h9);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("long_grant", 32'(bus.grant), 32'h4);
            chk("long_vld",   32'(bus.disp_valid), 32'h1);
        end

        // A competitor arriving in the open window takes over after exactly one edge.
        row = 1001;
        drive(0, 4'b0101, 4'h9);
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (bus.grant == 4'b0100 && waited < 6);
        chk("switch_latency", 32'(waited), 32'd1);
        chk("switch_grant",   32'(bus.grant), 32'h1);
        chk("switch_enc",     32'(bus.encoded), 32'h9A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_segment_arbiter.md
SEVEN_SEGMENT_ARBITER -- requirements
Module: seven_segment_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the display (2..8).
REQ-002 SHALL have parameter NUM_SEGMENTS, default 2: digits per display word.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000: minimum grant length in clk cycles (>=1); 0.5 s at a 10 ns clock.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, [NUM_REQ-1:0]: per-requester display request, level-sensitive.
REQ-007 SHALL have port req_encoded, input, [NUM_REQ-1:0][NUM_SEGMENTS-1:0][3:0]: per-requester hex digits.
REQ-008 SHALL have port req_dp, input, [NUM_REQ-1:0][NUM_SEGMENTS-1:0]: per-requester digit points.
REQ-009 SHALL have port grant, output, [NUM_REQ-1:0]: one-hot current owner; all-zero when idle.
REQ-010 SHALL have port owner_idx, output, [$clog2(NUM_REQ)-1:0]: binary index of the current owner.
REQ-011 SHALL have port disp_valid, output, 1: high while any owner holds the display.
REQ-012 SHALL have port encoded, output, [NUM_SEGMENTS-1:0][3:0]: digits forwarded to the display driver.
REQ-013 SHALL have port digit_point, output, [NUM_SEGMENTS-1:0]: digit points forwarded to the display driver.

Function
REQ-014 SHALL implement states IDLE, HOLD and OPEN; all outputs registered.
REQ-015 IDLE: grant=0 and disp_valid=0; encoded and digit_point hold their last values; if any req bit is set, the round-robin winner is loaded, the state moves to HOLD and cnt=0, with grant, owner_idx and disp_valid valid on the next edge (1-cycle latency).
REQ-016 Round-robin search SHALL start at index (last_owner+1) mod NUM_REQ and wrap; after reset, the search starts at index 0.
REQ-017 HOLD: cnt increments each cycle; the owner keeps the grant unconditionally for exactly HOLD_CYCLES cycles, even if its req drops.
REQ-018 In HOLD and OPEN, while the owner's req=1: encoded and digit_point SHALL register the owner's req_encoded and req_dp each cycle (1-cycle latency).
REQ-019 In HOLD and OPEN, while the owner's req=0: encoded and digit_point SHALL freeze at the last sampled value.
REQ-020 On the HOLD edge where cnt==HOLD_CYCLES-1, the OPEN rules SHALL be evaluated directly.
REQ-021 OPEN rule: if any non-owner req is set, switch to the round-robin winner, go to HOLD and set cnt=0.
REQ-022 OPEN rule: else if the owner's req=0, go to IDLE.
REQ-023 OPEN rule: else stay in OPEN; the owner keeps displaying indefinitely.
REQ-024 The owner's own req bit SHALL be excluded from the switch check in OPEN.
REQ-025 On a switch, the new owner's data SHALL appear on encoded/digit_point on the same edge that grant changes.
REQ-026 grant SHALL never have more than one bit set; owner_idx SHALL always match grant while disp_valid=1.
REQ-027 cnt SHALL be $clog2(HOLD_CYCLES+1) bits wide and SHALL never wrap; it saturates, unused, in OPEN.

Reset
REQ-028 While reset=1 at a clk edge, the block SHALL set state=IDLE, grant=0, owner_idx=0, disp_valid=0, encoded=0, digit_point=0, cnt=0 and the round-robin start to 0.
REQ-029 Reset SHALL take priority over every transition, including mid-HOLD and mid-switch; arbitration resumes on the first edge after reset deasserts.

Configuration
REQ-030 Macro SEG_ARB_OWNER_DP_EN defined: digit_point SHALL show owner_idx in binary (LSB on digit 0, zero-extended or truncated to NUM_SEGMENTS), requester req_dp SHALL be ignored, and digit_point=0 in IDLE; NUM_REQ <= 2**NUM_SEGMENTS is required.
REQ-031 Macro SEG_ARB_OWNER_DP_EN undefined: digit_point SHALL follow REQ-018 and REQ-019.

Verification (NUM_REQ=4, NUM_SEGMENTS=2, HOLD_CYCLES=4)
REQ-032 req=0001 with data {3,A} at cycle t in IDLE, req dropped at t+2 -> grant=0001 and encoded={3,A} on t+1..t+4; grant=0 and disp_valid=0 at t+5; encoded stays {3,A}.
REQ-033 req=1010 from IDLE after reset -> owner 1 for 4 cycles, then owner 3 for 4 cycles, then owner 1 again, with no idle cycle between grants.
REQ-034 req=0100 held alone past the hold time, then req=0101 at cycle t -> grant=0100 until t, grant=0001 at t+1.
REQ-035 Owner 3 in OPEN, req changes to 1001 -> next grant=0001 (wrap-around), owner_idx=0.
REQ-036 reset pulsed during the HOLD cycle cnt=2 -> next edge: grant=0, disp_valid=0, encoded=0; after release, req=0010 gives grant=0010 one cycle later.
REQ-037 SEG_ARB_OWNER_DP_EN defined, owner 2 with req_dp=11 -> digit_point=10; in IDLE, digit_point=00.
